practice_3: RTL and testbench

PRACTICE_3 -- requirements
Module: practice_3

---
 rtl/practice_3.sv | 87 ++++++++
 tb/tb_practice_3.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/practice_3.sv
// practice_3 -- four independent 4-bit counters sharing one clock, reset and enable.
//
// Parameters
//   C3_MAX   terminal value of the modulo counter oC3 (legal 1..15)
//
// Ports
//   iClk     system clock, every state update happens on its rising edge
//   iRst     asynchronous active-low reset, overrides everything
//   E_Count  synchronous active-high count enable shared by all counters
//   oC1      binary up-counter        0,1,...,15,0,...
//   oC2      binary down-counter      15,14,...,0,15,...
//   oC3      modulo up-counter        0,1,...,C3_MAX,0,...
//   oC4      Johnson twisted-ring     0000,1000,1100,1110,1111,0111,0011,0001,...
//
// Every output is a flop; no input reaches an output combinationally.
module practice_3 #(
  parameter int unsigned C3_MAX = 9
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       E_Count,
  output logic [3:0] oC1,
  output logic [3:0] oC2,
  output logic [3:0] oC3,
  output logic [3:0] oC4
);

  localparam logic [3:0] C3_TOP = 4'(C3_MAX);

  logic       johnValid;
  logic [3:0] johnNext;

  // Binary up-counter; natural 4-bit overflow gives the 15 -> 0 wrap.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oC1 <= 4'd0;
    end else if (E_Count) begin
      oC1 <= oC1 + 4'd1;
    end
  end

  // Binary down-counter; natural 4-bit underflow gives the 0 -> 15 wrap.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oC2 <= 4'hF;
    end else if (E_Count) begin
      oC2 <= oC2 - 4'd1;
    end
  end

  // Modulo counter. Using >= rather than == means any out-of-range value
  // (which can only appear through an upset) recovers to 0 on the next step.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oC3 <= 4'd0;
    end else if (E_Count) begin
      if (oC3 >= C3_TOP) begin
        oC3 <= 4'd0;
      end else begin
        oC3 <= oC3 + 4'd1;
      end
    end
  end

  // Only eight of the sixteen codes belong to the Johnson ring; a stray code
  // would otherwise circulate forever in a parasitic loop, so it is forced
  // back onto the ring at 1000.
  always_comb begin
    johnValid = 1'b0;
    case (oC4)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: johnValid = 1'b1;
      default:                             johnValid = 1'b0;
    endcase
    johnNext = johnValid ? {~oC4[0], oC4[3:1]} : 4'b1000;
  end

  // Johnson counter register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oC4 <= 4'b0000;
    end else if (E_Count) begin
      oC4 <= johnNext;
    end
  end

endmodule

// File: tb/tb_practice_3.sv
// tb_practice_3 -- directed self-checking bench for practice_3.
// Two instances share stimulus: dut uses the default C3_MAX=9, dut5 uses
// C3_MAX=5 so the short modulo wrap can be observed. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_practice_3;

  logic       iClk;
  logic       iRst;
  logic       E_Count;
  logic [3:0] oC1, oC2, oC3, oC4;
  logic [3:0] c1b, c2b, c3b, c4b;

  int testsRun    = 0;
  int testsFailed = 0;

  // Johnson ring in step order, indexed by (steps since reset) mod 8.
  logic [3:0] johnTab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

  practice_3 #(.C3_MAX(9)) dut (
    .iClk(iClk), .iRst(iRst), .E_Count(E_Count),
    .oC1(oC1), .oC2(oC2), .oC3(oC3), .oC4(oC4)
  );

  practice_3 #(.C3_MAX(5)) dut5 (
    .iClk(iClk), .iRst(iRst), .E_Count(E_Count),
    .oC1(c1b), .oC2(c2b), .oC3(c3b), .oC4(c4b)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Expected {oC1,oC2,oC3,oC4} after n enabled steps from reset, C3_MAX=9.
  function automatic logic [15:0] expAll(input int n);
    return {4'(n % 16), 4'(15 - (n % 16)), 4'(n % 10), johnTab[n % 8]};
  endfunction

  // Clean reset: assert for one cycle with the enable low, release at a negedge.
  task automatic applyReset();
    @(negedge iClk);
    E_Count = 1'b0;
    iRst    = 1'b0;
    @(negedge iClk);
    iRst    = 1'b1;
  endtask

  // Reset asserted between edges with the enable high must clear at once and hold.
  task automatic test_reset();
    iRst    = 1'b1;
    E_Count = 1'b1;
    repeat (3) @(negedge iClk);
    #2 iRst = 1'b0;
    #1;
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h0F00) begin
      testsFailed++;
      $display("[TB] FAIL reset_immediate: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h0F00);
    end
    testsRun++;
    if ({c1b, c2b, c3b, c4b} !== 16'h0F00) begin
      testsFailed++;
      $display("[TB] FAIL reset_immediate_c5: got %h expected %h", {c1b, c2b, c3b, c4b}, 16'h0F00);
    end
    repeat (2) @(negedge iClk);
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h0F00) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h0F00);
    end
  endtask

  // Released reset with the enable low: four edges, nothing moves.
  task automatic test_hold();
    E_Count = 1'b0;
    iRst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      testsRun++;
      if ({oC1, oC2, oC3, oC4} !== 16'h0F00) begin
        testsFailed++;
        $display("[TB] FAIL hold_edge%0d: got %h expected %h", i, {oC1, oC2, oC3, oC4}, 16'h0F00);
      end
    end
  endtask

  // A pulse on E_Count that is gone before the rising edge must not count.
  task automatic test_glitch();
    applyReset();
    #1 E_Count = 1'b1;
    #2 E_Count = 1'b0;
    @(negedge iClk);
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h0F00) begin
      testsFailed++;
      $display("[TB] FAIL glitch: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h0F00);
    end
  endtask

  // Five enabled edges from reset.
  task automatic test_count5();
    applyReset();
    E_Count = 1'b1;
    repeat (5) @(negedge iClk);
    E_Count = 1'b0;
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h5A57) begin
      testsFailed++;
      $display("[TB] FAIL count5: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h5A57);
    end
    testsRun++;
    if (c3b !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL count5_c5: got %0d expected %0d", c3b, 5);
    end
  endtask

  // Sixteen enabled edges: oC1/oC2 wrap back to reset values, oC3 sits at 6,
  // oC4 has completed two full rings, dut5 oC3 is at 16 mod 6 = 4.
  task automatic test_count16();
    applyReset();
    E_Count = 1'b1;
    repeat (16) @(negedge iClk);
    E_Count = 1'b0;
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h0F60) begin
      testsFailed++;
      $display("[TB] FAIL count16: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h0F60);
    end
    testsRun++;
    if (c3b !== 4'd4) begin
      testsFailed++;
      $display("[TB] FAIL count16_c5: got %0d expected %0d", c3b, 4);
    end
  endtask

  // Three 10-edge bursts separated by 2-edge gaps, checked every cycle
  // against the count of enabled edges seen so far.
  task automatic test_gaps();
    int n;
    logic en;
    n = 0;
    applyReset();
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 12; c++) begin
        en      = (c < 10);
        E_Count = en;
        @(negedge iClk);
        if (en) n++;
        testsRun++;
        if ({oC1, oC2, oC3, oC4} !== expAll(n)) begin
          testsFailed++;
          $display("[TB] FAIL gaps_b%0d_c%0d: got %h expected %h", b, c, {oC1, oC2, oC3, oC4}, expAll(n));
        end
        testsRun++;
        if (c3b !== 4'(n % 6)) begin
          testsFailed++;
          $display("[TB] FAIL gaps_c5_b%0d_c%0d: got %0d expected %0d", b, c, c3b, n % 6);
        end
      end
    end
    E_Count = 1'b0;
  endtask

  // Mid-sequence reset pulse with enable high, then release and step again.
  task automatic test_reset_pulse();
    int n;
    applyReset();
    E_Count = 1'b1;
    repeat (7) @(negedge iClk);
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h7871) begin
      testsFailed++;
      $display("[TB] FAIL pulse_pre: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h7871);
    end
    #2 iRst = 1'b0;
    #1;
    testsRun++;
    if ({oC1, oC2, oC3, oC4, c3b} !== 20'h0F000) begin
      testsFailed++;
      $display("[TB] FAIL pulse_clear: got %h expected %h", {oC1, oC2, oC3, oC4, c3b}, 20'h0F000);
    end
    @(negedge iClk);
    testsRun++;
    if ({oC1, oC2, oC3, oC4} !== 16'h0F00) begin
      testsFailed++;
      $display("[TB] FAIL pulse_hold: got %h expected %h", {oC1, oC2, oC3, oC4}, 16'h0F00);
    end
    iRst = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge iClk);
      n++;
      testsRun++;
      if ({oC1, oC2, oC3, oC4} !== expAll(n)) begin
        testsFailed++;
        $display("[TB] FAIL pulse_step%0d: got %h expected %h", n, {oC1, oC2, oC3, oC4}, expAll(n));
      end
      testsRun++;
      if (c3b !== 4'(n % 6)) begin
        testsFailed++;
        $display("[TB] FAIL pulse_c5_step%0d: got %0d expected %0d", n, c3b, n % 6);
      end
    end
    E_Count = 1'b0;
  endtask

  // Full ten-step run of the default modulo counter to see the 9 -> 0 wrap.
  task automatic test_c3_wrap();
    applyReset();
    E_Count = 1'b1;
    repeat (9) @(negedge iClk);
    testsRun++;
    if (oC3 !== 4'd9) begin
      testsFailed++;
      $display("[TB] FAIL c3_at_max: got %0d expected %0d", oC3, 9);
    end
    @(negedge iClk);
    E_Count = 1'b0;
    testsRun++;
    if (oC3 !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL c3_wrap: got %0d expected %0d", oC3, 0);
    end
  endtask

  initial begin
    iRst    = 1'b1;
    E_Count = 1'b0;
    test_reset();
    test_hold();
    test_glitch();
    test_count5();
    test_count16();
    test_gaps();
    test_reset_pulse();
    test_c3_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
